// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, config addresses, reset defaults and FSM states for the LIF scheduler
package lif_pkg;
  localparam int N_NEURONS = 4;
  localparam int W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REFR_W = 4;
  localparam int LEAK_W = 3;
  localparam logic [1:0] CFG_THRESH = 2'd0;
  localparam logic [1:0] CFG_LEAK = 2'd1;
  localparam logic [1:0] CFG_REFRACT = 2'd2;
  localparam logic [W-1:0] THRESH_RST = W'(200);
  localparam logic [LEAK_W-1:0] LEAK_RST = LEAK_W'(1);
  localparam logic [REFR_W-1:0] REFRACT_RST = REFR_W'(2);
  typedef enum logic [1:0] {IDLE, SWEEP, STALL, FINISH} state_t;
  function automatic logic [W-1:0] sat_add(logic [W-1:0] a, logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? '1 : s[W-1:0];
  endfunction
endpackage

// File: rtl/lif_scheduler_if.sv
// lif_scheduler_if: current-sample input and spike-event output handshakes
interface lif_scheduler_if;
  import lif_pkg::*;
  logic             cur_valid;
  logic             cur_ready;
  logic [IDX_W-1:0] cur_idx;
  logic [W-1:0]     cur_val;
  logic             spike_valid;
  logic             spike_ready;
  logic [IDX_W-1:0] spike_idx;
  modport master(output cur_valid, cur_idx, cur_val, spike_ready, input cur_ready, spike_valid, spike_idx);
  modport slave(input cur_valid, cur_idx, cur_val, spike_ready, output cur_ready, spike_valid, spike_idx);
endinterface

// File: rtl/lif_update.sv
// lif_update: combinational leak/integrate/saturate/threshold step for one neuron
module lif_update
  import lif_pkg::*;
(
  input  logic [W-1:0]      mem,
  input  logic [W-1:0]      acc,
  input  logic [REFR_W-1:0] refr,
  input  logic [W-1:0]      threshold,
  input  logic [LEAK_W-1:0] leak_shift,
  input  logic [REFR_W-1:0] refract_len,
  output logic [W-1:0]      mem_nxt,
  output logic [REFR_W-1:0] refr_nxt,
  output logic              spike
);
  logic [W:0]   v;
  logic [W-1:0] v_sat;
  always_comb begin
    v = {1'b0, mem - (mem >> leak_shift)} + {1'b0, acc};
    v_sat = v[W] ? '1 : v[W-1:0];
    spike = !(|refr) && v_sat >= threshold;
    mem_nxt = (|refr || spike) ? '0 : v_sat;
    refr_nxt = |refr ? refr - REFR_W'(1) : spike ? refract_len : '0;
  end
endmodule

// File: rtl/lif_scheduler.sv
// lif_scheduler: sweeps one shared LIF datapath over all neurons per tick and queues spikes in a FIFO
module lif_scheduler
  import lif_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [W-1:0]     cfg_data,
  lif_scheduler_if.slave   io,
  input  logic [IDX_W-1:0] state_sel,
  output logic [W-1:0]     state_out,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  state_t state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      mem [N_NEURONS];
  logic [W-1:0]      acc [N_NEURONS];
  logic [REFR_W-1:0] refr [N_NEURONS];
  logic [W-1:0]      threshold;
  logic [LEAK_W-1:0] leak_shift;
  logic [REFR_W-1:0] refract_len;
  logic [IDX_W-1:0]  fifo [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [W-1:0]      mem_nxt;
  logic [REFR_W-1:0] refr_nxt;
  logic              spike, full, pop, push, stall, commit;

  lif_update u_update (
    .mem(mem[idx]), .acc(acc[idx]), .refr(refr[idx]),
    .threshold, .leak_shift, .refract_len,
    .mem_nxt, .refr_nxt, .spike
  );

  assign full = wr_ptr == {~rd_ptr[PTR_W], rd_ptr[PTR_W-1:0]};
  assign pop = io.spike_valid && io.spike_ready;
  // A same-cycle pop frees the slot, so a spike into a full FIFO only stalls without one
  assign stall = state == SWEEP && spike && full && !pop;
  assign commit = state == SWEEP && !stall;
  assign push = commit && spike;
  assign io.cur_ready = 1'b1;
  assign io.spike_valid = wr_ptr != rd_ptr;
  assign io.spike_idx = fifo[rd_ptr[PTR_W-1:0]];
  assign state_out = mem[state_sel];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = tick ? SWEEP : IDLE;
      SWEEP:  state_nxt = stall ? STALL : idx == IDX_W'(N_NEURONS - 1) ? FINISH : SWEEP;
      STALL:  state_nxt = full ? STALL : SWEEP;
      FINISH: state_nxt = tick ? SWEEP : IDLE;
    endcase
  end

  always_comb begin
    busy = state == SWEEP || state == STALL;
    done = state == FINISH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      overrun <= 1'b0;
      threshold <= THRESH_RST;
      leak_shift <= LEAK_RST;
      refract_len <= REFRACT_RST;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i] <= '0;
        acc[i] <= '0;
        refr[i] <= '0;
      end
    end else begin
      if (tick && busy) overrun <= 1'b1;
      if (cfg_we && cfg_addr == CFG_THRESH) threshold <= cfg_data;
      if (cfg_we && cfg_addr == CFG_LEAK) leak_shift <= cfg_data[LEAK_W-1:0];
      if (cfg_we && cfg_addr == CFG_REFRACT) refract_len <= cfg_data[REFR_W-1:0];
      if (commit) begin
        idx <= idx + IDX_W'(1);
        mem[idx] <= mem_nxt;
        refr[idx] <= refr_nxt;
      end
      // A sample landing on the neuron being committed belongs to the next timestep
      for (int i = 0; i < N_NEURONS; i++) begin
        if (commit && idx == IDX_W'(i))
          acc[i] <= (io.cur_valid && io.cur_idx == IDX_W'(i)) ? io.cur_val : '0;
        else if (io.cur_valid && io.cur_idx == IDX_W'(i))
          acc[i] <= sat_add(acc[i], io.cur_val);
      end
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PTR_W-1:0]] <= idx;
  end
endmodule

// File: tb/tb_lif_scheduler.sv
// tb_lif_scheduler: directed and randomized checks of lif_scheduler against a per-timestep behavioural model
module tb_lif_scheduler;
  import lif_pkg::*;
  logic             clk = 1'b0;
  logic             rst, tick, cfg_we;
  logic [1:0]       cfg_addr;
  logic [W-1:0]     cfg_data;
  logic [IDX_W-1:0] state_sel;
  logic [W-1:0]     state_out;
  logic             busy, done, overrun;
  lif_scheduler_if bus();
  lif_scheduler dut (
    .clk, .rst, .tick, .cfg_we, .cfg_addr, .cfg_data, .io(bus),
    .state_sel, .state_out, .busy, .done, .overrun
  );
  always #5 clk = ~clk;

  int total = 0, bad = 0, seen = 0, rdy_mode = 0;
  int m_mem[N_NEURONS], m_acc[N_NEURONS], m_refr[N_NEURONS];
  int m_thr, m_leak, m_rlen;
  int exp_q[$];
  int leak_seq[8] = '{60, 30, 15, 8, 4, 2, 1, 1};
  int integ_seq[5] = '{150, 0, 0, 0, 150};

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N_NEURONS; i++) begin
      m_mem[i] = 0;
      m_acc[i] = 0;
      m_refr[i] = 0;
    end
    m_thr = 200;
    m_leak = 1;
    m_rlen = 2;
    exp_q.delete();
  endfunction

  // One whole timestep, neuron by neuron, straight from the update rule
  function automatic void m_sweep();
    int v;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (m_refr[i] > 0) begin
        m_mem[i] = 0;
        m_refr[i]--;
      end else begin
        v = m_mem[i] - (m_mem[i] >> m_leak) + m_acc[i];
        if (v > 255) v = 255;
        if (v >= m_thr) begin
          m_mem[i] = 0;
          m_refr[i] = m_rlen;
          exp_q.push_back(i);
        end else m_mem[i] = v;
      end
      m_acc[i] = 0;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
  endtask

  task automatic cfg(int a, int d);
    cfg_we = 1'b1;
    cfg_addr = a[1:0];
    cfg_data = d[W-1:0];
    step();
    cfg_we = 1'b0;
    if (a == 0) m_thr = d & 255;
    if (a == 1) m_leak = d & 7;
    if (a == 2) m_rlen = d & 15;
  endtask

  task automatic cur(int i, int v);
    bus.cur_valid = 1'b1;
    bus.cur_idx = i[IDX_W-1:0];
    bus.cur_val = v[W-1:0];
    step();
    bus.cur_valid = 1'b0;
    m_acc[i] = (m_acc[i] + v > 255) ? 255 : m_acc[i] + v;
  endtask

  task automatic start_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    m_sweep();
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    bit hit;
    lat = 0;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (k == 0) chk("busy_in_sweep", busy, 1);
      if (done) begin
        hit = 1'b1;
        lat = k;
      end
    end
    chk("done_seen", done, 1);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    chk("busy_at_done", busy, 0);
    step();
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_sel(string tag, int i, int exp);
    state_sel = i[IDX_W-1:0];
    @(negedge clk);
    chk(tag, state_out, exp);
    step();
  endtask

  task automatic check_states();
    for (int i = 0; i < N_NEURONS; i++) chk_sel("state", i, m_mem[i]);
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int k = 0; k < 50 && (bus.spike_valid || k < 2); k++) step();
    chk("drained", bus.spike_valid, 0);
    chk("spikes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    bus.spike_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.spike_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
    end
  end

  // Scoreboard: every accepted head must be the oldest spike the model predicted
  initial forever begin
    @(negedge clk);
    if (!rst && bus.spike_valid && bus.spike_ready) begin
      seen++;
      if (exp_q.size() == 0) chk("spike_unexpected", bus.spike_idx, -1);
      else chk("spike_idx", bus.spike_idx, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, extra;
    rst = 1'b1;
    tick = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    state_sel = '0;
    bus.cur_valid = 1'b0;
    bus.cur_idx = '0;
    bus.cur_val = '0;
    repeat (2) step();
    rst = 1'b0;
    m_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_spike_valid", bus.spike_valid, 0);
    chk("cur_ready", bus.cur_ready, 1);
    check_states();

    // integrate to spike, then refractory
    rdy_mode = 1;
    s0 = seen;
    for (int t = 0; t < 5; t++) begin
      cur(0, 150);
      start_tick();
      wait_done(N_NEURONS);
      chk_sel("integ_seq", 0, integ_seq[t]);
      check_states();
    end
    chk("integ_spikes", seen - s0, 1);
    drain();

    // leak only
    do_reset();
    cur(0, 120);
    start_tick();
    wait_done(N_NEURONS);
    chk_sel("leak_load", 0, 120);
    for (int t = 0; t < 8; t++) begin
      start_tick();
      wait_done(N_NEURONS);
      chk_sel("leak_seq", 0, leak_seq[t]);
      check_states();
    end

    // FIFO backpressure and stall
    rdy_mode = 0;
    do_reset();
    cfg(0, 1);
    cfg(2, 0);
    for (int i = 0; i < N_NEURONS; i++) cur(i, 10);
    start_tick();
    wait_done(N_NEURONS);
    chk("fifo_full_valid", bus.spike_valid, 1);
    for (int i = 0; i < N_NEURONS; i++) cur(i, 10);
    s0 = seen;
    start_tick();
    repeat (8) step();
    chk("stall_busy", busy, 1);
    chk("stall_valid", bus.spike_valid, 1);
    chk("stall_no_pop", seen - s0, 0);
    rdy_mode = 1;
    wait_done(-1);
    drain();
    chk("bp_spikes", seen - s0, 2 * N_NEURONS);
    check_states();

    // saturation and same-cycle collision
    do_reset();
    s0 = seen;
    cur(1, 200);
    cur(1, 200);
    cur(2, 30);
    start_tick();
    step();
    step();
    bus.cur_valid = 1'b1;
    bus.cur_idx = 2;
    bus.cur_val = 50;
    step();
    bus.cur_valid = 1'b0;
    m_acc[2] = 50;
    wait_done(-1);
    chk("sat_spike", seen - s0, 1);
    chk_sel("collide_now", 2, 30);
    check_states();
    start_tick();
    wait_done(N_NEURONS);
    chk_sel("collide_next", 2, 65);
    check_states();
    drain();

    // overrun, no extra sweep
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < N_NEURONS; i++) cur(i, 50);
    start_tick();
    chk("overrun_before", overrun, 0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_done(-1);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    step();
    chk("no_extra_sweep", extra, 0);
    chk("overrun_sticky", overrun, 1);
    check_states();

    // reset mid-sweep
    cfg(0, 10);
    for (int i = 0; i < N_NEURONS; i++) cur(i, 50);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_valid", bus.spike_valid, 0);
    check_states();
    cur(0, 150);
    start_tick();
    wait_done(N_NEURONS);
    check_states();
    chk("rst_thresh_default", bus.spike_valid, 0);

    // randomized timesteps
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) cfg(0, $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cfg(1, $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cfg(2, $urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) cfg(3, $urandom_range(0, 255));
      rdy_mode = 1;
      for (int k = $urandom_range(0, 5); k > 0; k--)
        cur($urandom_range(0, N_NEURONS - 1), $urandom_range(0, 255));
      rdy_mode = 2;
      start_tick();
      wait_done(-1);
      check_states();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
